// File: rtl/sysid_read_checker_pkg.sv
// Shared types and constants for the system-ID read-back self-check.
package sysid_read_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    FINISH
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_ID        = 32'd7;
  localparam logic [31:0] DEFAULT_TIMESTAMP = 32'd1384440210;

endpackage

// File: rtl/sysid_read_checker_port.sv
// Single-read Avalon-MM sequencer: read strobe held through waitrequest,
// fixed read-latency count and per-read stall timeout.
module sysid_read_checker_port #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic go,
  input  logic go_addr,
  input  logic avm_waitrequest,
  output logic avm_read,
  output logic avm_address,
  output logic accepted,
  output logic rd_done,
  output logic rd_timeout
);

  localparam logic [1:0]  LAT_LOAD    = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic        in_lat;
  logic [1:0]  lat_cnt;
  logic [15:0] stall_cnt;

  always_comb begin
    accepted   = avm_read & ~avm_waitrequest;
    rd_timeout = avm_read & avm_waitrequest & (stall_cnt == STALL_LIMIT);
    rd_done    = (READ_LATENCY == 0) ? accepted : (in_lat & (lat_cnt == '0));
  end

  // A new request wins over acceptance so latency-0 reads run back-to-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      in_lat      <= 1'b0;
      lat_cnt     <= '0;
      stall_cnt   <= '0;
    end else if (go) begin
      avm_read    <= 1'b1;
      avm_address <= go_addr;
      in_lat      <= 1'b0;
      stall_cnt   <= '0;
    end else if (avm_read) begin
      if (!avm_waitrequest) begin
        avm_read  <= 1'b0;
        stall_cnt <= '0;
        if (READ_LATENCY > 0) begin
          in_lat  <= 1'b1;
          lat_cnt <= LAT_LOAD;
        end
      end else if (rd_timeout) begin
        avm_read  <= 1'b0;
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end else if (in_lat) begin
      if (lat_cnt == '0) begin
        in_lat <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/sysid_read_checker.sv
// Hardware self-check: reads the sysid ID and timestamp words over Avalon-MM
// and compares them against build-time constants.
module sysid_read_checker
  import sysid_read_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_TIMESTAMP,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t state;
  logic   go;
  logic   go_addr;
  logic   accepted;
  logic   rd_done;
  logic   rd_timeout;

  sysid_read_checker_port #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_port (
    .clock          (clock),
    .reset          (reset),
    .go             (go),
    .go_addr        (go_addr),
    .avm_waitrequest(avm_waitrequest),
    .avm_read       (avm_read),
    .avm_address    (avm_address),
    .accepted       (accepted),
    .rd_done        (rd_done),
    .rd_timeout     (rd_timeout)
  );

  always_comb begin
    go      = 1'b0;
    go_addr = ADDR_ID;
    case (state)
      IDLE: begin
        go      = start;
        go_addr = ADDR_ID;
      end
      RD_ID, LAT_ID: begin
        go      = rd_done;
        go_addr = ADDR_TS;
      end
      default: begin
        go      = 1'b0;
        go_addr = ADDR_ID;
      end
    endcase
  end

  // RD_x and LAT_x share a branch: the port only reports timeout/acceptance
  // while its strobe is up, and data-done only at the right latency point.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RD_ID;
            busy    <= 1'b1;
            pass    <= 1'b0;
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b0;
          end
        end
        RD_ID, LAT_ID: begin
          if (rd_timeout) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FINISH;
          end else if (rd_done) begin
            id_value <= avm_readdata;
            state    <= RD_TS;
          end else if (accepted) begin
            state <= LAT_ID;
          end
        end
        RD_TS, LAT_TS: begin
          if (rd_timeout) begin
            timeout <= 1'b1;
            id_ok   <= (id_value == EXPECTED_ID);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FINISH;
          end else if (rd_done) begin
            ts_value <= avm_readdata;
            id_ok    <= (id_value == EXPECTED_ID);
            ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            pass     <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FINISH;
          end else if (accepted) begin
            state <= LAT_TS;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sysid_read_checker.md
Name: sysid_read_checker

Overview:
- Avalon-MM read initiator that fetches the system ID word (address 0) and timestamp word (address 1) from the system-ID slave.
- Compares both words against expected constants and reports pass/fail.
- Sits beside the sysid slave as a hardware self-check, so board bring-up is confirmed without a Nios II software run.
- Supports slave waitrequest, a fixed read latency, and a stall timeout.

Parameters:
- EXPECTED_ID, 32'd7, system ID value required at address 0
- EXPECTED_TIMESTAMP, 32'd1384440210, timestamp value required at address 1
- READ_LATENCY, 0, cycles from read acceptance to valid readdata; legal range 0..3
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles per read before abort; legal range 1..65535

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to run a check; ignored while busy=1
- avm_address  output  1  0 = ID word, 1 = timestamp word
- avm_read  output  1  read strobe
- avm_waitrequest  input  1  slave stall; tie 0 for the zero-wait sysid slave
- avm_readdata  input  32  slave read data
- busy  output  1  check in progress
- done  output  1  one-cycle pulse when a check completes or aborts
- pass  output  1  id_ok AND ts_ok AND NOT timeout; valid from done until the next start
- id_ok  output  1  captured ID equals EXPECTED_ID
- ts_ok  output  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout  output  1  last check aborted on a waitrequest stall
- id_value  output  32  captured ID word
- ts_value  output  32  captured timestamp word

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: all outputs 0, including id_value and ts_value. State goes to IDLE and all counters clear.
- Reset mid-operation: aborts the check, with avm_read low on the edge after reset is sampled. No done pulse is produced.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH.
- IDLE:
  - start=1 moves to RD_ID. On that edge, busy=1 and pass, id_ok, ts_ok and timeout clear.
  - Captured values hold until overwritten.
- RD_ID:
  - avm_read=1, avm_address=0, both registered outputs.
  - A read is accepted in a cycle where avm_read=1 and avm_waitrequest=0.
  - On acceptance with READ_LATENCY=0: capture avm_readdata into id_value that cycle, then go to RD_TS.
  - On acceptance with READ_LATENCY>0: drop avm_read, go to LAT_ID, and load the latency counter.
- LAT_ID: counts READ_LATENCY cycles after acceptance. Captures avm_readdata on the final count, then goes to RD_TS.
- RD_TS / LAT_TS: same as RD_ID / LAT_ID, with avm_address=1 and capture into ts_value. Then go to FINISH.
- Bus rules:
  - avm_address and avm_read stay stable while waitrequest=1.
  - avm_read drops in the cycle after acceptance unless the next state is another RD_* state.
  - Latency 0 gives back-to-back reads: ID accepted at cycle N, timestamp read asserted at N+1.
- FINISH:
  - id_ok and ts_ok register the comparisons.
  - pass = id_ok AND ts_ok.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Minimum check length with zero wait and latency 0: start at cycle 0, read ID at cycle 1, read timestamp at cycle 2, done at cycle 3.
- Timeout:
  - A 16-bit stall counter increments on each RD_* cycle with waitrequest=1. It clears on acceptance.
  - When the count reaches TIMEOUT_CYCLES: avm_read drops, timeout=1, pass=0, done pulses. Go to IDLE.
  - id_ok and ts_ok report only words actually captured; an uncaptured word reports 0.
- A start received while busy is dropped, not queued. A start in the same cycle as done is also dropped.
- Comparison is a full 32-bit equality test with no masking.

Decomposition:
- Shared package holds:
  - state enum
  - address constants ADDR_ID=1'b0, ADDR_TS=1'b1
  - default expected ID and timestamp constants
- One natural sub-module: sysid_read_checker_port, which holds the single-read Avalon master sequencer (read strobe, waitrequest hold, latency count, stall timeout). The top instantiates it once and issues two sequential transactions.

Test Plan:
- Zero-wait slave returning 7 at address 0 and 1384440210 at address 1, start pulse at cycle 0 -> reads at cycles 1 and 2, done at cycle 3, pass=1, id_value=7, ts_value=1384440210.
- Slave returns 8 at address 0 -> id_ok=0, ts_ok=1, pass=0, done still pulses once.
- waitrequest held high 5 cycles on the ID read -> address and read stable for all 5 cycles, one accepted read, pass=1, done at cycle 8.
- READ_LATENCY=2, data valid 2 cycles after each acceptance -> correct capture, avm_read low during LAT states, pass=1.
- TIMEOUT_CYCLES=10, waitrequest stuck high -> read drops after 10 stall cycles, timeout=1, pass=0, done once; a following start with a healthy slave passes.
- reset asserted in LAT_TS; also start pulsed while busy -> all outputs 0 the cycle after reset, no done; the busy start produces no second check.
